// File: rtl/aes_pkg.sv
// Shared AES-128 constants, state encoding and GF(2^8) helpers.
// Used by the iterative cipher core and the key-expansion block.
package aes_pkg;

    localparam int NB = 4;
    localparam int NK = 4;
    localparam int NR = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Forward S-box, byte 0x00 first; entry b sits at bits [8b +: 8].
    localparam logic [0:2047] SBOX_VEC = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_VEC[{b, 3'b000} +: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_cipher_iter_round.sv
// One AES encryption round as pure combinational logic:
// SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [0:127] state_in,
    input  logic [0:127] round_key,
    input  logic         last_round,
    output logic [0:127] state_out
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Byte k lives in row k%4, column k/4; row r takes its byte from column c+r.
    for (genvar k = 0; k < 16; k++) begin : g_sub_shift
        assign sb[k] = sbox(state_in[8*k +: 8]);
        assign sr[k] = sb[4*(((k/4) + (k%4)) % 4) + (k%4)];
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1]
                         ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2])
                         ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2])
                         ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
        assign mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1]
                         ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end

    for (genvar k = 0; k < 16; k++) begin : g_ark
        assign state_out[8*k +: 8] = (last_round ? sr[k] : mc[k]) ^ round_key[8*k +: 8];
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryption core: one round per clock on a single state
// register, fed by the unregistered expanded key schedule.
module aes_cipher_iter #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [0:127]            plaintext,
    input  logic [0:128*(NR+1)-1]   w,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [0:127]            ciphertext,
    output logic                    busy
);

    import aes_pkg::*;

    if (NK != 4) begin : g_nk_unsupported
        $error("aes_cipher_iter: only NK=4 (AES-128) is supported");
    end

    state_t       state, state_next;
    logic [0:127] state_reg;
    logic [0:127] round_out;
    logic [0:127] round_key;
    logic [3:0]   rnd;
    logic         last_round;

    logic [0:127] rk [NR+1];

    for (genvar r = 0; r <= NR; r++) begin : g_rk
        assign rk[r] = w[128*r +: 128];
    end

    assign round_key  = rk[rnd];
    assign last_round = (rnd == 4'(NR));
    assign ciphertext = state_reg;

    aes_round_comb u_round (
        .state_in   (state_reg),
        .round_key  (round_key),
        .last_round (last_round),
        .state_out  (round_out)
    );

    // Next-state and handshake outputs; DONE never raises in_ready, so a new
    // block can only be taken after a full pass through IDLE.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                busy = 1'b1;
                if (last_round) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, round counter and the data path register. The counter
    // parks at NR on the final round so it stays within 0..NR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            state_reg <= '0;
            rnd       <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= plaintext ^ rk[0];
                        rnd       <= 4'd1;
                    end
                end
                ROUND: begin
                    state_reg <= round_out;
                    if (!last_round) begin
                        rnd <= rnd + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Self-checking bench for aes_cipher_iter: FIPS-197 vectors, random blocks
// against a GF(2^8)-arithmetic reference model, and handshake corner cases.
`timescale 1ns/1ps
module tb_aes_cipher_iter;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [0:127]   plaintext;
    logic [0:1407]  w;
    logic           out_valid;
    logic           out_ready;
    logic [0:127]   ciphertext;
    logic           busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] sb_tab [256];

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           hold;
    } vec_t;

    vec_t vecs [8];

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_cipher_iter #(.NK(4), .NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .w          (w),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: field arithmetic and the cipher written from the AES rules.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic [0:1407] expand_key(input logic [127:0] key);
        logic [31:0]   wd [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1407] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) wd[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = wd[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            wd[i] = wd[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) res[32*i +: 32] = wd[i];
        return res;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [0:1407] ks;
        logic [7:0]    s [16];
        logic [7:0]    t [16];
        logic [127:0]  res;
        ks = expand_key(key);
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ ks[8*k +: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int k = 0; k < 16; k++) s[k] = sb_tab[s[k]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = s[4*((c+r)%4)+r];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rd != 10)
                        s[4*c+r] = gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4])
                                 ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
                    else
                        s[4*c+r] = t[4*c+r];
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ ks[128*rd + 8*k +: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt);
        w         = expand_key(key);
        plaintext = pt;
        in_valid  = 1'b1;
    endtask

    // Wait (bounded) for the accept edge; returns at the negedge just after it.
    task automatic waitAccept(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput({name, " accept"}, 128'(ok), 128'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        plaintext = rand128();
    endtask

    task automatic runBlock(input string name, input logic [127:0] key, input logic [127:0] pt,
                            input logic [127:0] exp_ct, input int hold, input int poke);
        int           lat;
        logic [127:0] held;
        applyStimulus(key, pt);
        waitAccept(name);
        checkOutput({name, " busy/in_ready in round"}, {126'd0, busy, in_ready}, 128'b10);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
            if (lat == poke) begin
                in_valid  = 1'b1;
                plaintext = rand128();
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checkOutput({name, " latency"}, 128'(lat), 128'd10);
        checkOutput({name, " ct"}, ciphertext, exp_ct);
        held = ciphertext;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({name, " hold ct"}, ciphertext, held);
            checkOutput({name, " hold flags"}, {125'd0, out_valid, in_ready, busy}, 128'b101);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({name, " release"}, {125'd0, out_valid, in_ready, busy}, 128'b010);
    endtask

    initial begin
        logic [7:0] inv;
        int         t_acc [2];
        int         acc;
        int         done;
        logic [127:0] exp2 [2];

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end

        vecs[0] = '{key: KEY_B, pt: PT_B, ct: CT_B, hold: 0};
        vecs[1] = '{key: KEY_C, pt: PT_C, ct: CT_C, hold: 1};
        for (int i = 2; i < 8; i++) begin
            vecs[i].key  = rand128();
            vecs[i].pt   = rand128();
            vecs[i].ct   = ref_encrypt(vecs[i].key, vecs[i].pt);
            vecs[i].hold = i % 3;
        end

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plaintext = '0;
        w         = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset flags", {125'd0, out_valid, in_ready, busy}, 128'b010);
        checkOutput("reset ct", ciphertext, 128'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            runBlock($sformatf("vec%0d", i), vecs[i].key, vecs[i].pt, vecs[i].ct, vecs[i].hold, 0);

        $display("[TB] backpressure and busy-input sequences");
        runBlock("backpressure", KEY_B, PT_B, CT_B, 5, 0);
        runBlock("busy poke", KEY_B, PT_B, CT_B, 0, 3);

        $display("[TB] reset mid-round sequence");
        applyStimulus(KEY_B, PT_B);
        waitAccept("abort");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort flags", {125'd0, out_valid, in_ready, busy}, 128'b010);
        checkOutput("abort ct", ciphertext, 128'd0);
        runBlock("after abort", KEY_C, PT_C, CT_C, 0, 0);

        $display("[TB] back-to-back sequence");
        exp2[0]   = CT_B;
        exp2[1]   = CT_C;
        acc       = 0;
        done      = 0;
        t_acc[0]  = 0;
        t_acc[1]  = 0;
        out_ready = 1'b1;
        applyStimulus(KEY_B, PT_B);
        for (int n = 0; n < 60 && done < 2; n++) begin
            if (acc == 2) in_valid = 1'b0;
            if (out_valid) begin
                checkOutput($sformatf("b2b ct%0d", done), ciphertext, exp2[done]);
                if (done == 0) begin
                    w         = expand_key(KEY_C);
                    plaintext = PT_C;
                end
                done++;
            end
            if (in_valid && in_ready && acc < 2) begin
                t_acc[acc] = n;
                acc++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b completed", 128'(done), 128'd2);
        checkOutput("b2b interval", 128'(t_acc[1] - t_acc[0]), 128'd12);
        repeat (2) @(negedge clk);
        checkOutput("b2b idle", {125'd0, out_valid, in_ready, busy}, 128'b010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_cipher_iter.md
Name: aes_cipher_iter

Overview:
Iterative low-area AES-128 encryption core. Sits directly downstream of the combinational key-expansion block and consumes its full expanded schedule `w` unregistered. It executes one AES round per clock on a single 128-bit state register, with valid/ready handshakes on the input and output sides.

Parameters:
NK, 4, key length in 32-bit words (only 4 is supported).
NR, 10, number of rounds. Sizes the `w` input and bounds the round counter.

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  plaintext and key schedule are presented
in_ready  output  1  core can accept a block (high only in IDLE)
plaintext  input  [0:127]  block to encrypt; bit 0 is the MSB of byte 0
w  input  [0:128*(NR+1)-1]  expanded key schedule; round key r = w[128*r +: 128]
out_valid  output  1  ciphertext is valid
out_ready  input  1  downstream accepts the ciphertext
ciphertext  output  [0:127]  encrypted block; driven directly from the state register
busy  output  1  high in ROUND or DONE

Behaviour:
- Reset (rst=1 at a clock edge), which overrides everything:
  - state <= IDLE; state register <= 0; round counter <= 0.
  - out_valid=0, busy=0, in_ready=1 after the edge.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: state reg <= plaintext ^ w[0:127]; rnd <= 1; go to ROUND.
- ROUND, each cycle: state reg <= SubBytes → ShiftRows → MixColumns(skipped when rnd==NR) → XOR w[128*rnd +: 128]; rnd <= rnd+1.
  - When rnd==NR, go to DONE.
- DONE:
  - out_valid=1 and ciphertext is stable.
  - Held until out_ready=1, then go to IDLE at that edge.
  - No timeout.
- Latency: input accepted at edge T0; out_valid rises after edge T0+NR (10 cycles).
  - Minimum issue interval is NR+2 cycles.
  - No back-to-back overlap: in_ready stays low in DONE even when out_ready=1 in that same cycle. The new accept happens in IDLE on the next cycle.
- Key stability: `w` is not captured. It must stay stable from the accept edge until out_valid rises. Changing it mid-block is undefined (no protection logic).
- plaintext is sampled only on the accept edge; later changes are ignored.
- in_valid while busy: ignored, not queued; the source must hold it.
- out_ready while not in DONE: ignored.
- Round counter: 4 bits, range 0..NR; it never wraps because DONE exits before increment.
- Byte/column order:
  - byte k = state[8k +: 8]; column c = bytes 4c..4c+3.
  - ShiftRows: row r rotates left by r columns.
  - MixColumns uses xtime with reduction polynomial 0x1b.
- ciphertext during IDLE/ROUND shows the intermediate state; it is meaningful only when out_valid=1.
- Reset asserted mid-ROUND or mid-DONE: the block is aborted with no output; the next block is accepted normally after rst drops.

Decomposition:
- Shared package aes_pkg:
  - constants NB=4, NK=4, NR=10
  - S-box function sbox(byte)
  - function xtime(byte)
  - rcon table
  - Reuse this package from key expansion to remove its duplicated S-box/rcon.
- Sub-module aes_round_comb, purely combinational:
  - inputs: state_in[0:127], round_key[0:127], last_round
  - output: state_out
  - implements SubBytes (16 sbox), ShiftRows, conditional MixColumns, AddRoundKey.
- The top level holds the FSM, round counter, state register and key-slice mux.

Test Plan:
- FIPS-197 App B: w from key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → out_valid exactly 10 cycles after accept, ct 3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → ct 69c4e0d86a7b0430d8cdb78070b4c55a.
- Output backpressure: hold out_ready=0 for 5 cycles after out_valid → ct and out_valid stable, in_ready=0 throughout; release → IDLE next cycle, in_ready=1.
- Busy input: pulse in_valid with a different plaintext during round 4 → no effect; App B ct still produced.
- Reset mid-operation: assert rst at round 6 for 1 cycle → out_valid=0, busy=0, ciphertext=0; a following App C.1 block yields the correct ct.
- Back-to-back: App B then App C.1 with in_valid held high and out_ready=1 → second accept one cycle after DONE exits, both cts correct, interval 12 cycles.
